// File: rtl/oled_pkg.sv
// Purpose: shared widths, default timing constants and FSM state type for the OLED refresh scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package oled_pkg;

    localparam int SCREEN_W = 9;
    localparam int NEEDS_W  = 33;
    localparam int CNT_W    = 32;

    localparam int unsigned DEF_REFRESH_CYCLES = 32'd25_000_000;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 32'd1_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

endpackage

// File: rtl/oled_cycle_counter.sv
// Purpose: 32-bit cycle counter with synchronous clear, enable and terminal-count flag at LIMIT-1.
// Latency: tc is a combinational decode of the current count; count wraps to 0 on the cycle after tc while enabled.
// Backpressure: none; en simply freezes the count.
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over en), en (count enable), tc (count == LIMIT-1).
module oled_cycle_counter
    import oled_pkg::*;
#(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/oled_refresh_scheduler.sv
// Purpose: coalesces screen/needs update requests and a periodic refresh tick into single OLED frame launches.
// Latency: request in IDLE at cycle N -> LOAD at N+1 -> frame_start at N+2; frames are separated by a holdoff gap.
// Backpressure: none toward requesters; requests arriving while a frame is in flight are latched (last value wins).
// Ports: scr_req/scr_param_in and needs_req/needs_in capture new content; frame_done ends a frame;
//        screen_param/needs_values feed the OLED driver; frame_start pulses per frame; busy spans the frame;
//        timeout_err is a sticky abort flag.
module oled_refresh_scheduler
    import oled_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scr_req,
    input  logic [SCREEN_W-1:0] scr_param_in,
    input  logic                needs_req,
    input  logic [NEEDS_W-1:0]  needs_in,
    input  logic                frame_done,
    output logic [SCREEN_W-1:0] screen_param,
    output logic [NEEDS_W-1:0]  needs_values,
    output logic                frame_start,
    output logic                busy,
    output logic                timeout_err
);

    state_t state;
    state_t state_nxt;

    logic                scr_pend;
    logic                needs_pend;
    logic                tmr_pend;
    logic [SCREEN_W-1:0] scr_shadow;
    logic [NEEDS_W-1:0]  needs_shadow;

    logic in_load;
    logic in_wait;
    logic in_holdoff;
    logic refresh_tc;
    logic holdoff_tc;
    logic timeout_tc;
    logic tmr_fire;
    logic holdoff_done;
    logic frame_timeout;
    logic new_work;

    assign in_load     = (state == ST_LOAD);
    assign in_wait     = (state == ST_WAIT_DONE);
    assign in_holdoff  = (state == ST_HOLDOFF);
    assign frame_start = (state == ST_START);
    assign busy        = (state == ST_START) || in_wait;

    // Refresh timer runs in every state except while waiting on the driver.
    oled_cycle_counter #(.LIMIT(REFRESH_CYCLES)) u_refresh_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (!in_wait),
        .tc    (refresh_tc)
    );

    oled_cycle_counter #(.LIMIT(HOLDOFF_CYCLES)) u_holdoff_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_holdoff),
        .en    (in_holdoff),
        .tc    (holdoff_tc)
    );

    // Frame age is measured from the frame_start cycle, so the abort lands
    // exactly TIMEOUT_CYCLES cycles after the launch pulse.
    oled_cycle_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy),
        .en    (busy),
        .tc    (timeout_tc)
    );

    assign tmr_fire      = refresh_tc && !in_wait;
    assign holdoff_done  = holdoff_tc && in_holdoff;
    assign frame_timeout = timeout_tc && in_wait && !frame_done;

    // Requests seen this very cycle count as work so IDLE reaches LOAD on the
    // following cycle. Priority among sources (screen, needs, timer) has no
    // visible effect: a single LOAD snapshots both shadows and serves all.
    assign new_work = scr_pend || needs_pend || tmr_pend ||
                      scr_req || needs_req || tmr_fire;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (new_work) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (frame_done || frame_timeout) state_nxt = ST_HOLDOFF;
            ST_HOLDOFF:   if (holdoff_done) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request landing in the LOAD cycle re-arms its pend flag, so it is
    // served by the next frame rather than being swallowed by this clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_pend   <= 1'b0;
            needs_pend <= 1'b0;
            tmr_pend   <= 1'b0;
        end else begin
            scr_pend   <= scr_req   || (scr_pend   && !in_load);
            needs_pend <= needs_req || (needs_pend && !in_load);
            tmr_pend   <= tmr_fire  || (tmr_pend   && !in_load);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_shadow   <= '0;
            needs_shadow <= '0;
        end else begin
            if (scr_req)   scr_shadow   <= scr_param_in;
            if (needs_req) needs_shadow <= needs_in;
        end
    end

    // Driver-facing values only move in LOAD, so they are frozen for the
    // whole START/WAIT_DONE window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_param <= '0;
            needs_values <= '0;
        end else if (in_load) begin
            screen_param <= scr_shadow;
            needs_values <= needs_shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (frame_timeout) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: doc/oled_refresh_scheduler.md
OLED_REFRESH_SCHEDULER -- requirements
Module: oled_refresh_scheduler

Interface
REQ-001 Parameter REFRESH_CYCLES, default 25_000_000: periodic redraw interval in clk cycles.
REQ-002 Parameter HOLDOFF_CYCLES, default 1_000: minimum idle gap between frames.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000: frame abort limit.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 scr_req  in  1  one-cycle request for a new screen.
REQ-007 scr_param_in  in  9  screen selector sampled with scr_req.
REQ-008 needs_req  in  1  one-cycle request for updated need bars.
REQ-009 needs_in  in  33  need values sampled with needs_req.
REQ-010 frame_done  in  1  one-cycle pulse from the OLED driver when a full frame has been sent.
REQ-011 screen_param  out  9  selector presented to the OLED driver.
REQ-012 needs_values  out  33  values presented to the OLED driver.
REQ-013 frame_start  out  1  one-cycle pulse that launches a frame.
REQ-014 busy  out  1  high from frame_start until frame_done, timeout, or reset.
REQ-015 timeout_err  out  1  sticky flag set on frame timeout, cleared only by reset.

Function
REQ-016 States: IDLE, LOAD, START, WAIT_DONE, HOLDOFF.
REQ-017 Pending capture: scr_req sets scr_pend and latches scr_param_in into a shadow register. needs_req sets needs_pend and latches needs_in. Capture happens in every state.
REQ-018 Coalescing: a repeat request while its pend flag is set overwrites the shadow register; last value wins.
REQ-019 Refresh timer: counts every cycle except in WAIT_DONE. At REFRESH_CYCLES-1 it sets tmr_pend and wraps to 0.
REQ-020 IDLE -> LOAD when any pend flag is set.
REQ-021 Arbitration priority in LOAD: scr_pend, then needs_pend, then tmr_pend.
REQ-022 LOAD copies both shadow registers to screen_param/needs_values and clears all three pend flags in the same cycle. One frame serves all pending requests.
REQ-023 Simultaneous events: a request arriving in the LOAD cycle is kept pending; it is neither lost nor cleared.
REQ-024 LOAD -> START, one cycle. START drives frame_start=1 for exactly one cycle and sets busy; next state is WAIT_DONE.
REQ-025 screen_param/needs_values are stable from LOAD until the next LOAD; they never change while busy=1.
REQ-026 WAIT_DONE on frame_done -> HOLDOFF, busy=0. On a wait counter reaching TIMEOUT_CYCLES-1 without frame_done -> HOLDOFF, busy=0, timeout_err=1.
REQ-027 frame_done outside WAIT_DONE is ignored.
REQ-028 HOLDOFF waits HOLDOFF_CYCLES cycles, then goes to IDLE. Pends accumulate meanwhile.
REQ-029 Latency: request in IDLE at cycle N -> LOAD at N+1, frame_start at N+2.
REQ-030 All counters are 32-bit unsigned. Comparisons use parameter-1 values. Parameters below 1 are illegal.

Reset
REQ-031 rst_n=0 forces, asynchronously: state=IDLE; all pends=0; counters=0; screen_param=0; needs_values=0; shadows=0; frame_start=0; busy=0; timeout_err=0.
REQ-032 Reset asserted mid-frame abandons the frame; no frame_start follows release unless a new request or the timer fires.
REQ-033 First periodic frame occurs REFRESH_CYCLES cycles after reset release.

Structure
REQ-034 Shared package oled_pkg holds:
- state enum
- SCREEN_W=9
- NEEDS_W=33
- default parameter constants
REQ-035 Sub-module oled_cycle_counter, instantiated three times (refresh, holdoff, timeout): clear, enable, terminal-count output.
REQ-036 Block drives top_oled inputs only; it does not modify master_i2c_oled or ssd1306_master.

Verification
REQ-037 Single request: scr_req with param 9'h005 in IDLE.
- LOAD next cycle; frame_start 2 cycles after scr_req; screen_param=9'h005.
- frame_done -> busy=0.
REQ-038 Coalescing during a frame: while busy, needs_req with 33'h1_0000_00AA, then 33'h0_0000_0055, then scr_req with param 3.
- Exactly one frame_start after HOLDOFF.
- That frame carries needs_values=33'h0_0000_0055 and screen_param=3.
REQ-039 Simultaneous arrival: needs_req asserted in the LOAD cycle of a screen frame -> a second frame_start after frame_done plus HOLDOFF.
REQ-040 Timeout: TIMEOUT_CYCLES=100, frame_done never sent.
- busy falls 100 cycles after frame_start; timeout_err=1 and stays 1.
- Next request still produces frame_start.
REQ-041 Periodic refresh: REFRESH_CYCLES=200, no requests -> frame_start at cycles 201, 401+frame time, ...; timer frozen during WAIT_DONE.
REQ-042 Reset mid-frame: rst_n low in WAIT_DONE -> all outputs 0 immediately; no frame_start within REFRESH_CYCLES-1 cycles after release.
